rs232in_fifo: RTL and testbench
===============================

# rs232in_fifo

Receive-side byte buffer between the `rs232in` deserializer and the `rs232` peripheral register block. It captures every byte strobed by `rs232in` and holds it in a small circular FIFO until the CPU pops it. It reports occupancy and a sticky overrun flag, and drives hardware flow control (`ser_nrts`) with hysteresis, so bursts at 115 200 bps survive slow software polling.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes.
- `RTS_OFF`, 12: occupancy at or above which `ser_nrts` is raised (sender told to stop).
- `RTS_ON`, 4: occupancy at or below which `ser_nrts` is lowered again; must be < `RTS_OFF`.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rs232in_data` in 8: received byte from `rs232in`.
- `rs232in_attention` in 1: one-cycle strobe; `rs232in_data` is valid this cycle.
- `rd` in 1: pop request from `rs232` peripheral.
- `rd_data` out 8: head byte; valid whenever `empty`=0.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==2^DEPTH_LOG2.
- `overrun` out 1: sticky; a byte was dropped.
- `clear_overrun` in 1: clears `overrun`.
- `ser_nrts` out 1: flow control, 1 = stop sending.

## Operation
- Storage: 2^DEPTH_LOG2 × 8 register/LUT array. Write pointer `wp` and read pointer `rp` are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is a separate DEPTH_LOG2+1-bit register.
- Push is `rs232in_attention` & (~`full` | `rd`). On push, `mem[wp]` ← data and `wp` ← `wp`+1.
- Pop is `rd` & ~`empty`. On pop, `rp` ← `rp`+1.
- `rd` while empty is ignored. No pointer or count change, no error.
- Attention while full and `rd`=0: byte dropped, `overrun` ← 1, FIFO contents unchanged.
- Simultaneous push+pop when full: both occur, `count` stays full, no overrun.
- Simultaneous attention+`rd` when empty: push only, `count` → 1. The new byte is not popped that cycle.
- `count` next = `count` + push − pop. `empty` and `full` are derived from registered `count`.
- `overrun`: set by a dropped byte, cleared by `clear_overrun`. If both happen in the same cycle, set wins.
- `rd_data` = `mem[rp]`, combinational read of the registered array. This is first-word-fall-through.
- Flow control: `ser_nrts` ← 1 when next `count` ≥ `RTS_OFF`, and ← 0 when next `count` ≤ `RTS_ON`. Otherwise it holds its value.

## Timing
- Reset (`rst`=1 at an edge): `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `ser_nrts`=0. Array contents are not reset, so `rd_data` is undefined while empty.
- Reset mid-operation discards all buffered bytes. A strobe coincident with `rst` is dropped.
- Write latency: strobe at edge N → `empty`=0, `count` updated and `rd_data` valid after edge N. A pop is possible in cycle N+1.
- Pop: `rd` sampled at edge N. `rd_data` must be consumed in the same cycle `rd` is high, and shows the next byte after edge N.
- `ser_nrts` is registered and changes at the same edge as `count`. There is no extra lag.
- Throughput: one push and one pop per cycle.
- Pointer wrap: `wp` and `rp` go from 2^DEPTH_LOG2−1 to 0 with no bubble.

## Test plan
Defaults apply: depth 16, `RTS_OFF` 12, `RTS_ON` 4.
- **Reset / basic FWFT.** After reset, check `empty`=1, `count`=0, `ser_nrts`=0. Strobe 0x41, then check `count`=1 and `rd_data`=0x41. Pulse `rd`, then check `empty`=1.
- **Fill / overrun.** Strobe 0x00..0x10 (17 bytes) with no reads: `full`=1 after 16, the 17th sets `overrun`=1, `count` stays 16. Popping all 16 yields 0x00..0x0F in order. `clear_overrun` → `overrun`=0.
- **Wrap-around.** Repeat 40 times: push 3, pop 3, interleaved. Every popped byte equals the pushed sequence and `count` never exceeds 3.
- **Simultaneous events.**
  - Full + attention + `rd` in one cycle: `count` stays 16, `overrun` stays 0, the pushed byte appears last.
  - Empty + attention + `rd`: `count`=1, byte retained.
  - `clear_overrun` coinciding with a drop: `overrun` stays 1.
- **Flow-control hysteresis.**
  - Push 11 bytes: `ser_nrts`=0.
  - 12th byte: `ser_nrts`=1.
  - Pop down to 5: `ser_nrts` stays 1.
  - Pop to 4: `ser_nrts`=0.
- **Reset mid-stream.** With 7 bytes buffered and `ser_nrts`=0, assert `rst` for one cycle together with a strobe: `count`=0, `empty`=1, `overrun`=0, and the next pushed byte reads back first.

Source files
------------

// File: rtl/rs232in_fifo.sv
// Receive byte buffer between the rs232in deserializer and the rs232 register block:
// a first-word-fall-through circular FIFO with sticky overrun and RTS hysteresis.
module rs232in_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_OFF    = 12,
    parameter int RTS_ON     = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [7:0]            rs232in_data,
    input  logic                  rs232in_attention,
    input  logic                  rd,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    input  logic                  clear_overrun,
    output logic                  ser_nrts
);

    // Handshake: rs232in_attention is a one-cycle strobe with no back-pressure; a byte
    // arriving while full (and not popped that cycle) is dropped and flagged. rd is a pop
    // request honoured only while !empty; rd_data is the head byte and is valid whenever
    // !empty, so it must be consumed in the same cycle rd is high.

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_OFF  = (DEPTH_LOG2 + 1)'(RTS_OFF);
    localparam logic [DEPTH_LOG2:0]   COUNT_ON   = (DEPTH_LOG2 + 1)'(RTS_ON);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DEPTH_LOG2:0]   count_next;

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push = rs232in_attention & (~full | rd);
    assign pop  = rd & ~empty;
    assign drop = rs232in_attention & full & ~rd;

    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + COUNT_ONE;
        end
        if (pop) begin
            count_next = count_next - COUNT_ONE;
        end
    end

    assign rd_data = mem[rp];

    // Storage is not reset; a strobe coincident with rst is discarded.
    always_ff @(posedge clock) begin
        if (push && !rst) begin
            mem[wp] <= rs232in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // A drop in the same cycle as clear_overrun leaves the flag set.
    always_ff @(posedge clock) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Hysteresis is evaluated on the next occupancy so RTS moves on the same edge as count.
    always_ff @(posedge clock) begin
        if (rst) begin
            ser_nrts <= 1'b0;
        end else if (count_next >= COUNT_OFF) begin
            ser_nrts <= 1'b1;
        end else if (count_next <= COUNT_ON) begin
            ser_nrts <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs232in_fifo.sv
// Directed bench for rs232in_fifo: queue scoreboard for byte order plus hand-computed
// checks of count, flags and flow control at each step.
module tb_rs232in_fifo;

    logic       clock;
    logic       rst;
    logic [7:0] rs232in_data;
    logic       rs232in_attention;
    logic       rd;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       clear_overrun;
    logic       ser_nrts;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    rs232in_fifo dut (
        .clock             (clock),
        .rst               (rst),
        .rs232in_data      (rs232in_data),
        .rs232in_attention (rs232in_attention),
        .rd                (rd),
        .rd_data           (rd_data),
        .count             (count),
        .empty             (empty),
        .full              (full),
        .overrun           (overrun),
        .clear_overrun     (clear_overrun),
        .ser_nrts          (ser_nrts)
    );

    // clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One cycle of stimulus; the scoreboard follows FIFO semantics independently.
    task automatic step(input logic att, input logic [7:0] d, input logic r, input logic clr);
        int  size;
        logic do_pop;
        logic do_push;
        size = exp_q.size();
        rs232in_attention = att;
        rs232in_data      = d;
        rd                = r;
        clear_overrun     = clr;
        #1;
        do_pop  = r && (size > 0);
        do_push = att && ((size < 16) || r);
        if (do_pop) begin
            check("rd_data", {24'd0, rd_data}, {24'd0, exp_q[0]});
            void'(exp_q.pop_front());
        end
        if (do_push) exp_q.push_back(d);
        tick();
        rs232in_attention = 1'b0;
        rd                = 1'b0;
        clear_overrun     = 1'b0;
    endtask

    task automatic do_reset(input logic att, input logic [7:0] d);
        rst               = 1'b1;
        rs232in_attention = att;
        rs232in_data      = d;
        tick();
        rst               = 1'b0;
        rs232in_attention = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] seq;
        rst = 1'b0; rs232in_data = 8'h00; rs232in_attention = 1'b0;
        rd = 1'b0; clear_overrun = 1'b0;
        tick();

        // reset and basic first-word-fall-through
        do_reset(1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_nrts", 32'(ser_nrts), 32'd0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check("fwft_count", 32'(count), 32'd1);
        check("fwft_data", 32'(rd_data), 32'h41);
        check("fwft_empty", 32'(empty), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_empty_count", 32'(count), 32'd0);
        check("rd_empty_flag", 32'(empty), 32'd1);

        // fill and overrun
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 15) begin
                check("fill_full", 32'(full), 32'd1);
                check("fill_count16", 32'(count), 32'd16);
                check("fill_no_ovr", 32'(overrun), 32'd0);
            end
        end
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_count", 32'(count), 32'd16);
        check("ovr_nrts", 32'(ser_nrts), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovr_clear", 32'(overrun), 32'd0);

        // wrap-around
        seq = 8'h20;
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 3; j++) begin
                step(1'b1, seq, 1'b0, 1'b0);
                seq = seq + 8'd1;
            end
            check("wrap_count", 32'(count), 32'd3);
            for (int j = 0; j < 3; j++) step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // full + attention + rd
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        check("sim_full", 32'(full), 32'd1);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("sim_full_count", 32'(count), 32'd16);
        check("sim_full_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_full_drain", 32'(empty), 32'd1);

        // empty + attention + rd
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("sim_empty_count", 32'(count), 32'd1);
        check("sim_empty_data", 32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // clear_overrun coinciding with a drop
        for (int i = 0; i < 16; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("clr_drop_ovr", 32'(overrun), 32'd1);
        check("clr_drop_count", 32'(count), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_after", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("clr_drain_nrts", 32'(ser_nrts), 32'd0);

        // flow-control hysteresis
        for (int i = 0; i < 11; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        check("hys_11_count", 32'(count), 32'd11);
        check("hys_11_nrts", 32'(ser_nrts), 32'd0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        check("hys_12_nrts", 32'(ser_nrts), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("hys_5_count", 32'(count), 32'd5);
        check("hys_5_nrts", 32'(ser_nrts), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("hys_4_nrts", 32'(ser_nrts), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("hys_drain", 32'(empty), 32'd1);

        // reset mid-stream with a coincident strobe
        for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        check("mid_count7", 32'(count), 32'd7);
        check("mid_nrts", 32'(ser_nrts), 32'd0);
        do_reset(1'b1, 8'h99);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ovr", 32'(overrun), 32'd0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("mid_first", 32'(rd_data), 32'h5A);
        check("mid_first_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("mid_end_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
